// File: rtl/mac_result_fifo.sv
// Result FIFO behind the multiply-accumulate unit: first-word-fall-through storage,
// valid/ready drain, overflow drops counted in a saturating counter.
module mac_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       validi,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       readyi,
    output logic                       valido,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;

    // Flags and handshake decode, all from registered occupancy
    always_comb begin
        full_s  = (level_r == LW'(DEPTH));
        empty_s = (level_r == {LW{1'b0}});
        pop_s   = !empty_s && readyi;
        // A full FIFO still accepts a word when the head leaves in the same cycle
        push_s  = validi && (!full_s || pop_s);
        drop_s  = validi && full_s && !pop_s;
    end

    // Pointer, occupancy and drop-counter state
    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            level_r    <= {LW{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
            if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_W'(1'b1);
            end
        end
    end

    // Storage write; the array itself is never cleared
    always_ff @(posedge clk) begin
        if (rst_ && push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Output presentation; head word forced to zero while empty
    always_comb begin
        valido   = !empty_s;
        full     = full_s;
        empty    = empty_s;
        level    = level_r;
        drop_cnt = drop_cnt_r;
        if (!empty_s) begin
            data_out = mem_r[rd_ptr_r];
        end else begin
            data_out = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_mac_result_fifo.sv
// Directed bench for mac_result_fifo: reset, pass-through, fill/drain, overflow,
// saturation, full push+pop, pointer wrap and mid-operation reset.
module tb_mac_result_fifo;

    logic        clk;
    logic        rst_;
    logic        validi;
    logic [31:0] data_in;
    logic        readyi;
    logic        valido;
    logic [31:0] data_out;
    logic        full;
    logic        empty;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    int checks;
    int errors;
    logic [31:0] q[$];
    int model_drops;

    mac_result_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .validi   (validi),
        .data_in  (data_in),
        .readyi   (readyi),
        .valido   (valido),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        model_drops = 0;
        rst_    = 1'b0;
        validi  = 1'b1;
        data_in = 32'hDEAD;
        readyi  = 1'b0;

        // Reset held two cycles with upstream trying to push
        tick();
        tick();
        rst_   = 1'b1;
        validi = 1'b0;
        chk("rst_valido", {31'd0, valido}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        tick();
        chk("rst_nostore", {29'd0, level}, 32'd0);

        // Single pass-through, one-cycle latency
        readyi  = 1'b1;
        validi  = 1'b1;
        data_in = 32'd7;
        tick();
        validi = 1'b0;
        chk("pt_valido", {31'd0, valido}, 32'd1);
        chk("pt_data", data_out, 32'd7);
        chk("pt_level1", {29'd0, level}, 32'd1);
        tick();
        chk("pt_level0", {29'd0, level}, 32'd0);
        chk("pt_empty_data", data_out, 32'd0);

        // Fill and hold
        readyi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            validi  = 1'b1;
            data_in = 32'd10 + 32'(i);
            tick();
        end
        validi = 1'b0;
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_level", {29'd0, level}, 32'd4);
        chk("fill_head", data_out, 32'd10);
        tick();
        chk("hold_head", data_out, 32'd10);
        chk("hold_valido", {31'd0, valido}, 32'd1);
        readyi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", data_out, 32'd10 + 32'(i));
            tick();
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Overflow: refill, then three drops
        readyi = 1'b0;
        for (int i = 0; i < 7; i++) begin
            validi  = 1'b1;
            data_in = (i < 4) ? 32'd10 + 32'(i) : 32'd50 + 32'(i);
            tick();
        end
        validi = 1'b0;
        chk("ovf_drop", {24'd0, drop_cnt}, 32'd3);
        chk("ovf_level", {29'd0, level}, 32'd4);
        chk("ovf_head", data_out, 32'd10);

        // Full with simultaneous push and pop
        readyi  = 1'b1;
        validi  = 1'b1;
        data_in = 32'd99;
        tick();
        validi = 1'b0;
        chk("pp_level", {29'd0, level}, 32'd4);
        chk("pp_drop", {24'd0, drop_cnt}, 32'd3);
        chk("pp_seq0", data_out, 32'd11);
        tick();
        chk("pp_seq1", data_out, 32'd12);
        tick();
        chk("pp_seq2", data_out, 32'd13);
        tick();
        chk("pp_seq3", data_out, 32'd99);
        tick();
        chk("pp_empty", {31'd0, empty}, 32'd1);

        // Saturation: refill then 300 drops
        readyi = 1'b0;
        for (int i = 0; i < 4; i++) begin
            validi  = 1'b1;
            data_in = 32'd200 + 32'(i);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            data_in = 32'd1000 + 32'(i);
            tick();
        end
        validi = 1'b0;
        chk("sat_drop", {24'd0, drop_cnt}, 32'd255);
        chk("sat_level", {29'd0, level}, 32'd4);
        chk("sat_head", data_out, 32'd200);

        // Clear, then stream across pointer wrap with readyi toggling
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        chk("clr_drop", {24'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            validi  = 1'b1;
            data_in = 32'd100 + 32'(i);
            readyi  = (i % 2 == 0);
            chk("wrap_level", {29'd0, level}, 32'(q.size()));
            if (readyi && q.size() > 0) begin
                chk("wrap_data", data_out, q[0]);
                void'(q.pop_front());
            end
            if (q.size() < 4) q.push_back(data_in);
            else model_drops++;
            tick();
        end
        validi = 1'b0;
        readyi = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (q.size() > 0) begin
                chk("wrap_tail", data_out, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        chk("wrap_empty", {31'd0, empty}, 32'd1);
        chk("wrap_drops", {24'd0, drop_cnt}, 32'(model_drops));

        // Mid-operation reset with three entries stored
        readyi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            validi  = 1'b1;
            data_in = 32'd300 + 32'(i);
            tick();
        end
        validi = 1'b0;
        chk("mid_level3", {29'd0, level}, 32'd3);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        chk("mid_valido", {31'd0, valido}, 32'd0);
        chk("mid_level", {29'd0, level}, 32'd0);
        chk("mid_data", data_out, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
Downstream stage of the three-input multiply-accumulate unit (data_out = a*b+c, valido pulsed per result). It captures every valido/data_out result into a small first-word-fall-through FIFO and presents it to a consumer over a valid/ready handshake. The upstream unit has no backpressure, so results arriving when the FIFO is full are dropped and counted.

Parameters:
WIDTH, 32, data width of each result word
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of the saturating drop counter

Ports:
clk  input  1  single clock, all logic on posedge
rst_  input  1  reset, synchronous, active-low
validi  input  1  result valid from upstream (upstream valido)
data_in  input  WIDTH  result word from upstream (upstream data_out)
readyi  input  1  consumer ready to take the head word
valido  output  1  head word valid (FIFO not empty)
data_out  output  WIDTH  head word; 0 when empty
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  $clog2(DEPTH)+1  current occupancy
drop_cnt  output  CNT_W  results lost to overflow, saturating

Behaviour:
- Reset is decided as one clock, synchronous, active-low on rst_. Sampled at posedge clk when rst_==0: wr_ptr=0, rd_ptr=0, level=0, drop_cnt=0. Outputs then read valido=0, data_out=0, empty=1, full=0. Storage array is not cleared.
- Reset mid-operation discards all stored entries. drop_cnt clears. No pop is reported in the reset cycle.
- pop = valido && readyi. push = validi && (!full || pop).
- Push writes data_in at wr_ptr; wr_ptr increments mod DEPTH. Pop increments rd_ptr mod DEPTH. Pointers wrap naturally at DEPTH.
- level next = level + push - pop. It never exceeds DEPTH and never goes below 0.
- Full plus simultaneous validi and readyi: pop and push both occur, level stays DEPTH, and no drop is counted.
- Full plus validi with readyi==0: the word is dropped and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1 and holds.
- Empty plus validi: the word is written at posedge N and valido=1 with data_out=word from cycle N+1. There is no same-cycle bypass, so first-word latency is 1 cycle.
- Empty plus readyi: no pop occurs and nothing changes.
- valido=!empty is registered-state derived (from level), not combinational from inputs. data_out=mem[rd_ptr] when valido, else 0.
- Data and valido must hold stable while valido && !readyi.
- Order is strictly FIFO; no reordering and no duplication.
- full, empty and level are derived from the registered level only.

Test Plan:
- Reset: drive rst_=0 for 2 cycles with validi=1, data_in=32'hDEAD -> valido=0, data_out=0, level=0, drop_cnt=0 after release; no word stored.
- Single pass-through: readyi=1, one validi pulse with data_in=7 -> valido=1, data_out=7 exactly one cycle later; popped next edge; level back to 0.
- Fill and hold: readyi=0, push 10,11,12,13 -> full=1, level=4, data_out=10 held stable. Then readyi=1 for 4 cycles -> outputs 10,11,12,13 in order, empty=1.
- Overflow: with full and readyi=0, push 3 more words -> drop_cnt=3, level=4, contents still 10..13. Drive 300 drops with CNT_W=8 -> drop_cnt saturates at 255.
- Simultaneous push/pop at full: full with head 10 and readyi=1, push 99 -> level stays 4, drop_cnt unchanged, 99 emerges after 11,12,13.
- Wrap and mid-op reset: stream 20 words with readyi toggling 1010.. -> output sequence matches input order across pointer wrap. Assert rst_=0 with level=3 -> next cycle valido=0, level=0, data_out=0.
